load_store_unit: RTL
====================

# load_store_unit

Memory-access stage that sits directly downstream of the ALU in the RV32I datapath. It takes the effective address computed by the ALU (ADD path for LB/LH/LW/LBU/LHU/SB/SH/SW) plus the store operand. It drives a word-addressed data-memory port with byte enables through a request/acknowledge handshake. It returns sign- or zero-extended load data, or an error code, to writeback and holds the pipeline until the access completes.

## Interface
- TIMEOUT, 255, number of consecutive ACCESS cycles without `dmem_ack` before a bus-timeout error; legal range ≥1
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset (sampled on `clk` rising edge)
- req_valid  in  1  access request from the ALU stage
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  32  effective byte address (ALU `alu_out`)
- store_data  in  32  rs2 value
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid with `rsp_valid`
- load_data  out  32  extended load result; 0 for stores and errors
- dmem_req  out  1  memory request, held until ack or timeout
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wen  out  4  byte write enables; 0000 for loads
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word, valid when `dmem_ack` high
- dmem_ack  in  1  one-cycle completion from memory

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On accept, latch is_store, funct3, addr, and store_data, then check:
  - illegal: loads with funct3 ∈ {011,110,111}; stores with funct3 ∉ {000,001,010}.
  - misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
  - Illegal takes priority over misaligned.
  - On error: go to RESP with that code; no memory request is issued.
  - Otherwise: go to ACCESS and clear the timeout counter.
- ACCESS:
  - Drive `dmem_req`=1, `dmem_addr`, `dmem_wen`, `dmem_wdata` from the latched fields; all stable for the whole state.
  - Store enables: SB `dmem_wen`=0001<<addr[1:0], `dmem_wdata`={4{byte}}; SH addr[1]?1100:0011, `dmem_wdata`={2{half}}; SW 1111.
  - On `dmem_ack`: capture the extracted/extended `dmem_rdata` and go to RESP with rsp_err=00.
  - Load extraction: LB/LBU take the byte at lane addr[1:0]; LH/LHU take the half at lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes the word.
  - Without ack: increment the counter. When TIMEOUT cycles have elapsed with no ack, go to RESP with err 11.
  - An ack in the final allowed cycle counts as success.
  - Counter width is $clog2(TIMEOUT+1).
- RESP: `rsp_valid`=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- `dmem_ack` outside ACCESS is ignored.
- `req_valid` outside IDLE is ignored; the upstream stage must hold its request.

## Timing
- Reset (rst_n low at an edge): state→IDLE, counter→0.
  - Output values after reset: rsp_valid 0, rsp_err 00, load_data 0, dmem_req 0, dmem_addr 0, dmem_wen 0000, dmem_wdata 0, req_ready 1.
  - Reset mid-ACCESS drops `dmem_req` at that edge with no response issued.
  - Reset overrides any simultaneous ack or request.
- Accept at edge E0 → ACCESS during cycle 1 (`dmem_req` high). An ack during cycle 1 → `rsp_valid` in cycle 2.
- Minimum latency: 2 cycles from accept to `rsp_valid`. Minimum back-to-back spacing: 3 cycles per access.
- Error path latency: 1 cycle (RESP in the cycle after accept); `dmem_req` never rises.
- Timeout: `rsp_valid` with err 11 in the cycle after the TIMEOUT-th ACCESS cycle.
- `load_data` and `rsp_err` are registered. They hold their values after `rsp_valid` falls until the next RESP.

## Test plan
- Reset, then LW addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF → dmem_addr 0x100, dmem_wen 0000, rsp_valid in cycle 2, load_data 0xDEADBEEF, err 00.
- LB addr 0x103 with rdata 0x80FF7F01 → 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF; LHU → 0x000080FF.
- SB addr 0x201, store_data 0x000000AB → dmem_addr 0x200, wen 0010, wdata 0xABABABAB; SH addr 0x202, store_data 0x1234 → wen 1100, wdata 0x12341234; load_data 0.
- LW addr 0x102 → rsp err 01 one cycle after accept with dmem_req never high; load funct3 011 → err 10; store funct3 100 → err 10.
- TIMEOUT=4, LW with no ack → dmem_req high exactly 4 cycles, then rsp err 11. Repeat with ack in the 4th cycle → err 00.
- Assert rst_n low during ACCESS with ack in the same cycle → no rsp_valid, dmem_req 0, req_ready 1 next cycle. A following LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage driving a word-addressed data port with byte enables and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_rsp_valid,
  output logic [1:0]  o_rsp_err,
  output logic [31:0] o_load_data,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t r_state, w_next;
  logic          r_is_store;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr, r_store_data, r_load_data;
  logic [1:0]    r_err;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_ill, w_mis, w_access, w_tmo;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  assign w_accept = r_state == IDLE && i_req_valid;
  assign w_ill = i_is_store ? (i_funct3[2] || i_funct3[1:0] == 2'b11)
                            : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
  assign w_mis = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
  assign w_access = r_state == ACCESS;
  assign w_tmo = w_access && !i_dmem_ack && r_cnt == CW'(TIMEOUT - 1);
  assign w_byte = r_addr[1] ? (r_addr[0] ? i_dmem_rdata[31:24] : i_dmem_rdata[23:16])
                            : (r_addr[0] ? i_dmem_rdata[15:8]  : i_dmem_rdata[7:0]);
  assign w_half = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  always_comb begin
    w_ext = i_dmem_rdata;
    if (r_funct3[1:0] == 2'b00) w_ext = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
    else if (r_funct3[1:0] == 2'b01) w_ext = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
  end
  always_ff @(posedge i_clk)
    r_state <= !i_rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = (w_ill || w_mis) ? RESP : ACCESS;
    else if (w_access && (i_dmem_ack || w_tmo)) w_next = RESP;
    else if (r_state == RESP) w_next = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_store_data <= 32'h0;
      r_load_data  <= 32'h0;
      r_err        <= 2'b00;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_is_store   <= i_is_store;
      r_funct3     <= i_funct3;
      r_addr       <= i_addr;
      r_store_data <= i_store_data;
      r_cnt        <= '0;
      if (w_ill || w_mis) begin
        r_err       <= w_ill ? 2'b10 : 2'b01;
        r_load_data <= 32'h0;
      end
    end else if (w_access) begin
      r_cnt <= r_cnt + CW'(1);
      if (i_dmem_ack) begin
        r_err       <= 2'b00;
        r_load_data <= r_is_store ? 32'h0 : w_ext;
      end else if (w_tmo) begin
        r_err       <= 2'b11;
        r_load_data <= 32'h0;
      end
    end
  end
  assign o_req_ready  = r_state == IDLE;
  assign o_rsp_valid  = r_state == RESP;
  assign o_rsp_err    = r_err;
  assign o_load_data  = r_load_data;
  assign o_dmem_req   = w_access;
  assign o_dmem_addr  = w_access ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_dmem_wen   = !(w_access && r_is_store) ? 4'b0000 :
                        r_funct3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0] :
                        r_funct3[1:0] == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign o_dmem_wdata = !(w_access && r_is_store) ? 32'h0 :
                        r_funct3[1:0] == 2'b00 ? {4{r_store_data[7:0]}} :
                        r_funct3[1:0] == 2'b01 ? {2{r_store_data[15:0]}} : r_store_data;
endmodule
